posit_enc_arbiter: RTL and testbench

POSIT_ENC_ARBITER -- requirements
Module: posit_enc_arbiter

---
 rtl/posit_enc_arbiter.sv | 140 ++++++++++++++
 tb/tb_posit_enc_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_enc_arbiter.sv
// Two-requester round-robin front end for a multi-cycle posit encoder.
// Owns the encoder command bus, guards each job with a timeout and returns one tagged result.
module posit_enc_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_sign,
    input  logic [5:0]  req0_k,
    input  logic [2:0]  req0_exp,
    input  logic [31:0] req0_mant,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_sign,
    input  logic [5:0]  req1_k,
    input  logic [2:0]  req1_exp,
    input  logic [31:0] req1_mant,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,

    output logic        enc_start,
    output logic        enc_sign,
    output logic [5:0]  enc_k,
    output logic [2:0]  enc_exp,
    output logic [31:0] enc_mant,
    output logic        enc_rst_n,
    input  logic        enc_done,
    input  logic [31:0] enc_p,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             rr_ptr;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             grant0;
    logic             grant1;

    // rr_ptr names the requester that wins when both are valid at once
    assign grant0     = req0_valid && (!req1_valid || !rr_ptr);
    assign grant1     = req1_valid && (!req0_valid ||  rr_ptr);
    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            enc_start <= 1'b0;
            enc_sign  <= 1'b0;
            enc_k     <= '0;
            enc_exp   <= '0;
            enc_mant  <= '0;
            enc_rst_n <= 1'b0;
        end else begin
            enc_start <= 1'b0;
            enc_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner     <= grant1;
                        rr_ptr    <= !grant1;
                        enc_sign  <= grant1 ? req1_sign : req0_sign;
                        enc_k     <= grant1 ? req1_k    : req0_k;
                        enc_exp   <= grant1 ? req1_exp  : req0_exp;
                        enc_mant  <= grant1 ? req1_mant : req0_mant;
                        enc_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the final timeout cycle still counts as success
                    if (enc_done) begin
                        rsp_data  <= enc_p;
                        rsp_err   <= 1'b0;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        enc_sign  <= 1'b0;
                        enc_k     <= '0;
                        enc_exp   <= '0;
                        enc_mant  <= '0;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_id    <= owner;
                        rsp_valid <= 1'b1;
                        enc_rst_n <= 1'b0;
                        enc_sign  <= 1'b0;
                        enc_k     <= '0;
                        enc_exp   <= '0;
                        enc_mant  <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_enc_arbiter.sv
// Randomised scoreboard bench for posit_enc_arbiter with a posit<32,3> encoder stub.
// Expected order comes from a round-robin model and expected data from a bit-string posit encoder.
module tb_posit_enc_arbiter;

    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sign;
    logic [5:0]  req0_k;
    logic [2:0]  req0_exp;
    logic [31:0] req0_mant;
    logic        req1_valid, req1_ready, req1_sign;
    logic [5:0]  req1_k;
    logic [2:0]  req1_exp;
    logic [31:0] req1_mant;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic        enc_start, enc_sign, enc_rst_n, enc_done, busy;
    logic [5:0]  enc_k;
    logic [2:0]  enc_exp;
    logic [31:0] enc_mant, enc_p;

    // mode 0: done after w WAIT cycles, mode 1: never done, mode 2: done on the last WAIT cycle
    typedef struct {
        logic        sign;
        logic [5:0]  k;
        logic [2:0]  e;
        logic [31:0] mant;
        int          mode;
        int          w;
        int          acc_cyc;
    } op_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    op_t  q0[$];
    op_t  q1[$];
    op_t  stub_q[$];
    rsp_t exp_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   reset_count = 0;
    int   start_cnt = 0;
    int   acc_cnt = 0;
    int   rdy_mode = 0;
    logic prio = 1'b0;

    posit_enc_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sign(req0_sign),
        .req0_k(req0_k), .req0_exp(req0_exp), .req0_mant(req0_mant),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sign(req1_sign),
        .req1_k(req1_k), .req1_exp(req1_exp), .req1_mant(req1_mant),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .enc_start(enc_start), .enc_sign(enc_sign), .enc_k(enc_k),
        .enc_exp(enc_exp), .enc_mant(enc_mant), .enc_rst_n(enc_rst_n),
        .enc_done(enc_done), .enc_p(enc_p), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(negedge clk);
        if (rst && enc_start) start_cnt++;
    end

    // Sign, regime run, 3 exponent bits, mantissa; truncate to 32 bits, negate for negative sign
    function automatic logic [31:0] posit_ref(input logic s, input logic [5:0] k,
                                              input logic [2:0] e, input logic [31:0] m);
        logic [127:0] bits;
        logic [31:0]  mag;
        int           pos;
        int           kk;
        bits = '0;
        pos  = 126;
        kk   = int'($signed(k));
        if (kk >= 0) begin
            for (int i = 0; i <= kk; i++) begin
                bits[pos] = 1'b1;
                pos--;
            end
            pos--;
        end else begin
            pos = pos + kk;
            bits[pos] = 1'b1;
            pos--;
        end
        for (int i = 2; i >= 0; i--) begin
            bits[pos] = e[i];
            pos--;
        end
        for (int i = 31; i >= 0; i--) begin
            bits[pos] = m[i];
            pos--;
        end
        mag = bits[127:96];
        return s ? (~mag + 32'd1) : mag;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic applyStimulus(input int r, input int mode, input int w, input logic s,
                                 input logic [5:0] k, input logic [2:0] e, input logic [31:0] m);
        op_t o;
        o.sign = s;
        o.k = k;
        o.e = e;
        o.mant = m;
        o.mode = mode;
        o.w = w;
        o.acc_cyc = 0;
        if (r == 0) q0.push_back(o);
        else q1.push_back(o);
    endtask

    task automatic applyRandom(input int r, input int mode, input int w);
        applyStimulus(r, mode, w, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                      3'($urandom_range(0, 7)), $urandom());
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_enc_start", enc_start, 0);
        checkOutput("rst_enc_bus", {enc_sign, enc_k, enc_exp, enc_mant[21:0]}, 0);
        checkOutput("rst_enc_mant", enc_mant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_enc_rst_n", enc_rst_n, 0);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + exp_q.size() + stub_q.size()) != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) checkOutput("drain_timeout", 1, 0);
        repeat (4) @(negedge clk);
    endtask

    // Requester driver plus round-robin reference: winner is the sole valid one, else prio
    initial begin
        req0_valid = 0; req0_sign = 0; req0_k = '0; req0_exp = '0; req0_mant = '0;
        req1_valid = 0; req1_sign = 0; req1_k = '0; req1_exp = '0; req1_mant = '0;
        forever begin
            @(posedge clk);
            #1;
            req0_valid = (q0.size() > 0);
            if (req0_valid) begin
                req0_sign = q0[0].sign; req0_k = q0[0].k; req0_exp = q0[0].e; req0_mant = q0[0].mant;
            end
            req1_valid = (q1.size() > 0);
            if (req1_valid) begin
                req1_sign = q1[0].sign; req1_k = q1[0].k; req1_exp = q1[0].e; req1_mant = q1[0].mant;
            end
            @(negedge clk);
            if (!rst) begin
                prio = 1'b0;
            end else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                int   winner;
                int   taken;
                op_t  o;
                rsp_t e;
                winner = (req0_valid && req1_valid) ? int'(prio) : (req0_valid ? 0 : 1);
                taken  = (req1_valid && req1_ready) ? 1 : 0;
                checkOutput("grant_id", taken, winner);
                checkOutput("single_grant", req0_ready && req1_ready, 0);
                if (winner == 0) o = q0[0];
                else o = q1[0];
                e.id   = (winner == 1);
                e.err  = (o.mode == 1);
                e.data = (o.mode == 1) ? 32'd0 : posit_ref(o.sign, o.k, o.e, o.mant);
                exp_q.push_back(e);
                if (taken == 0) o = q0.pop_front();
                else o = q1.pop_front();
                o.acc_cyc = cyc;
                stub_q.push_back(o);
                prio = (winner == 0);
                acc_cnt++;
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 3) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Encoder stub: also times the response and counts enc_rst_n low cycles per job
    op_t         s_o;
    logic [31:0] s_p;
    int          s_snap, s_w, s_lows, s_lat;
    logic        s_fire, s_seen;
    initial begin
        enc_done = 1'b0;
        enc_p    = '0;
        forever begin
            @(negedge clk);
            if (rst && enc_start) begin
                if (stub_q.size() == 0) begin
                    checkOutput("start_unexpected", 1, 0);
                end else begin
                    s_o    = stub_q.pop_front();
                    s_snap = reset_count;
                    checkOutput("start_latency", cyc, s_o.acc_cyc + 1);
                    s_p    = posit_ref(enc_sign, enc_k, enc_exp, enc_mant);
                    s_fire = (s_o.mode != 1);
                    s_w    = (s_o.mode == 0) ? s_o.w : TIMEOUT - 1;
                    s_lows = 0;
                    s_lat  = 0;
                    s_seen = 1'b0;
                    for (int i = 0; i < TIMEOUT + 10; i++) begin
                        @(posedge clk);
                        #1;
                        enc_done = s_fire && (i == s_w);
                        enc_p    = enc_done ? s_p : $urandom();
                        @(negedge clk);
                        if (reset_count != s_snap) begin
                            if (i > s_w) break;
                        end else begin
                            if (i == 0) checkOutput("enc_start_pulse", enc_start, 0);
                            if (!enc_rst_n) s_lows++;
                            if (s_seen) break;
                            if (rsp_valid) begin
                                s_seen = 1'b1;
                                s_lat  = i + 1;
                            end
                        end
                    end
                    enc_done = 1'b0;
                    if (reset_count == s_snap) begin
                        checkOutput("rsp_latency", s_seen ? s_lat : 0, s_w + 2);
                        checkOutput("enc_rst_n_pulse", s_lows, s_fire ? 0 : 1);
                    end
                end
            end
        end
    end

    // Monitor: hold stability under backpressure, and pop/compare on each handshake
    logic        m_pv = 1'b0;
    logic [31:0] m_pd;
    logic        m_pid, m_perr;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_pv = 1'b0;
            end else if (rsp_valid) begin
                checkOutput("ready_in_resp", {req0_ready, req1_ready}, 0);
                if (m_pv) begin
                    checkOutput("hold_data", rsp_data, m_pd);
                    checkOutput("hold_id", rsp_id, m_pid);
                    checkOutput("hold_err", rsp_err, m_perr);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_rsp", 1, 0);
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        checkOutput("rsp_id", rsp_id, e.id);
                        checkOutput("rsp_data", rsp_data, e.data);
                        checkOutput("rsp_err", rsp_err, e.err);
                    end
                    m_pv = 1'b0;
                end else begin
                    m_pv   = 1'b1;
                    m_pd   = rsp_data;
                    m_pid  = rsp_id;
                    m_perr = rsp_err;
                end
            end else begin
                m_pv = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int snap;
        int seen;
        rst = 1'b0;
        rdy_mode = 0;

        for (int i = 0; i < 3; i++) begin
            applyRandom(0, 0, $urandom_range(0, 4));
            applyRandom(1, 0, $urandom_range(0, 4));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("enc_rst_n_in_reset", enc_rst_n, 0);
        @(negedge clk);
        checkOutput("enc_rst_n_release", enc_rst_n, 1);
        waitIdle();

        applyStimulus(0, 0, 3, 1'b0, 6'd0, 3'd0, 32'd0);
        waitIdle();

        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int d;
            d = $urandom_range(0, 19);
            applyRandom($urandom_range(0, 1), (d < 14) ? 0 : ((d < 17) ? 1 : 2), $urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) applyRandom($urandom_range(0, 1), 0, $urandom_range(0, 6));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        waitIdle();

        rdy_mode = 2;
        applyRandom(0, 0, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        checkOutput("bp_rsp_seen", rsp_valid, 1);
        applyRandom(1, 0, 1);
        snap = start_cnt;
        repeat (10) @(negedge clk);
        checkOutput("bp_no_start", start_cnt - snap, 0);
        checkOutput("bp_valid_held", rsp_valid, 1);
        rdy_mode = 0;
        waitIdle();

        applyRandom(0, 1, 0);
        waitIdle();
        applyRandom(1, 2, 0);
        waitIdle();

        applyRandom(0, 0, 30);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enc_start && n < 50);
        checkOutput("rst_test_start", enc_start, 1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_count++;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("enc_rst_n_after_abort", enc_rst_n, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput("no_rsp_after_reset", seen, 0);

        applyRandom(1, 0, 2);
        applyRandom(0, 0, 2);
        waitIdle();

        checkOutput("start_count", start_cnt, acc_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
